// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// Multiplies and divides hold busy for a fixed cycle count; MTHI/MTLO complete in one cycle.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [0:0]    state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;

  // Result datapath, evaluated from the latched operands only
  logic [63:0] sa, sb, prod_s, prod_u;
  logic        a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag, den_s, den_u;
  logic [31:0] sq_mag, sr_mag, quo_s, rem_s, quo_u, rem_u;

  always_comb begin
    sa     = {{32{a_q[31]}}, a_q};
    sb     = {{32{b_q[31]}}, b_q};
    prod_s = sa * sb;
    prod_u = {32'd0, a_q} * {32'd0, b_q};

    a_neg  = a_q[31];
    b_neg  = b_q[31];
    b_zero = (b_q == 32'd0);
    a_mag  = a_neg ? (~a_q + 32'd1) : a_q;
    b_mag  = b_neg ? (~b_q + 32'd1) : b_q;
    // Zero divisor is substituted so the dividers stay defined; the result is discarded anyway
    den_s  = b_zero ? 32'd1 : b_mag;
    den_u  = b_zero ? 32'd1 : b_q;

    // Magnitude divide keeps 0x80000000 / -1 well defined (quotient wraps to 0x80000000)
    sq_mag = a_mag / den_s;
    sr_mag = a_mag % den_s;
    quo_s  = (a_neg ^ b_neg) ? (~sq_mag + 32'd1) : sq_mag;
    rem_s  = a_neg ? (~sr_mag + 32'd1) : sr_mag;
    quo_u  = a_q / den_u;
    rem_u  = a_q % den_u;
  end

  // Next-state and register-update logic
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              state_d = ST_BUSY;
              cnt_d   = CW'(MULT_CYCLES);
              op_d    = op;
              a_d     = A;
              b_d     = B;
            end
            OP_DIV, OP_DIVU: begin
              state_d = ST_BUSY;
              cnt_d   = CW'(DIV_CYCLES);
              op_d    = op;
              a_d     = A;
              b_d     = B;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        if (cnt != '0) cnt_d = cnt - CW'(1);
        if (cnt <= CW'(1)) begin
          state_d = ST_IDLE;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV: begin
              if (!b_zero) begin
                hi_d = rem_s;
                lo_d = quo_s;
              end
            end
            OP_DIVU: begin
              if (!b_zero) begin
                hi_d = rem_u;
                lo_d = quo_u;
              end
            end
            default: ;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op_q  <= 3'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  assign busy = (state == ST_BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: vector table through a result scoreboard,
// plus hand sequences for busy-time issue, back-to-back issue and reset abort.
module tb_mdu;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  localparam int NVEC  = 15;
  localparam int LIMIT = 200;

  vec_t vecs [NVEC];
  exp_t sb_q [$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Drive one op, push its expectation, count busy cycles while scrambling A/B, then score it
  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    int   n;
    @(negedge clk);
    start = 1'b1; op = v.op; A = v.a; B = v.b;
    sb_q.push_back('{hi: v.hi, lo: v.lo, cyc: v.cyc});
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    n = 0;
    while (busy && n < LIMIT) begin
      n++;
      A = $urandom;
      B = $urandom;
      @(posedge clk); #1;
    end
    e = sb_q.pop_front();
    chk($sformatf("vec%0d busy_cycles", idx), 32'(n), 32'(e.cyc));
    chk($sformatf("vec%0d HI", idx), HI, e.hi);
    chk($sformatf("vec%0d LO", idx), LO, e.lo);
  endtask

  initial begin
    int   n;
    exp_t e;

    vecs[0]  = '{3'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{3'd5, 32'h00000011, 32'h00000000, 32'h00000011, 32'hFFFFFFFD, 0};
    vecs[4]  = '{3'd6, 32'h00000022, 32'h00000000, 32'h00000011, 32'h00000022, 0};
    vecs[5]  = '{3'd4, 32'h00000007, 32'h00000000, 32'h00000011, 32'h00000022, 10};
    vecs[6]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[7]  = '{3'd4, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 10};
    vecs[8]  = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[9]  = '{3'd3, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 10};
    vecs[10] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs[11] = '{3'd0, 32'h00000005, 32'h00000009, 32'h40000000, 32'h00000000, 0};
    vecs[12] = '{3'd7, 32'h00000005, 32'h00000009, 32'h40000000, 32'h00000000, 0};
    vecs[13] = '{3'd2, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
    vecs[14] = '{3'd3, 32'h00000005, 32'h00000000, 32'h00000001, 32'h00000000, 10};

    reset = 1'b1; start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset HI", HI, 32'd0);
    chk("reset LO", LO, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

    // MTLO while busy is ignored; MTHI in the first idle cycle takes effect
    @(negedge clk);
    start = 1'b1; op = 3'd1; A = 32'd2; B = 32'd3;
    sb_q.push_back('{hi: 32'd0, lo: 32'd6, cyc: 5});
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    @(negedge clk);
    start = 1'b1; op = 3'd6; A = 32'hDEAD;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    chk("mtlo_in_busy LO", LO, 32'd0);
    chk("mtlo_in_busy HI", HI, 32'd1);
    while (busy && n < LIMIT) begin
      n++;
      @(posedge clk); #1;
    end
    e = sb_q.pop_front();
    chk("mult_b2b busy_cycles", 32'(n), 32'(e.cyc));
    chk("mult_b2b HI", HI, e.hi);
    chk("mult_b2b LO", LO, e.lo);
    @(negedge clk);
    start = 1'b1; op = 3'd5; A = 32'hBEEF;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    chk("mthi_b2b HI", HI, 32'hBEEF);
    chk("mthi_b2b LO", LO, 32'd6);
    chk("mthi_b2b busy", 32'(busy), 32'd0);

    // Reset during the third busy cycle of a divide aborts it without a late write
    @(negedge clk);
    start = 1'b1; op = 3'd3; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    chk("abort busy_c1", 32'(busy), 32'd1);
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("abort busy_c3", 32'(busy), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort HI", HI, 32'd0);
    chk("abort LO", LO, 32'd0);
    reset = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
    end
    chk("post_abort busy", 32'(busy), 32'd0);
    chk("post_abort HI", HI, 32'd0);
    chk("post_abort LO", LO, 32'd0);

    // Op issued in the first cycle after reset deasserts
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    run_vec(100, '{3'd2, 32'd3, 32'd4, 32'd0, 32'd12, 5});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5, SHALL set the busy duration in cycles for MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, default 10, SHALL set the busy duration in cycles for DIV/DIVU.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 Port start  input  1  SHALL request execution of op in the current cycle.
REQ-006 Port op  input  3  SHALL encode the operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
REQ-007 Port A  input  32  SHALL be operand rs (the dividend for DIV/DIVU; the source for MTHI/MTLO).
REQ-008 Port B  input  32  SHALL be operand rt (the divisor for DIV/DIVU).
REQ-009 Port busy  output  1  SHALL be high while a multiply or divide is in flight.
REQ-010 Port HI  output  32  SHALL reflect the HI register.
REQ-011 Port LO  output  32  SHALL reflect the LO register.

Function
REQ-012 Acceptance: a request SHALL be accepted at a rising edge only when start=1, busy=0 and reset=0.
REQ-013 Requests with start=1 while busy=1 SHALL be ignored, with no state change; the pipeline stalls externally.
REQ-014 An accepted MULT/MULTU/DIV/DIVU SHALL latch A and B and load the counter with MULT_CYCLES or DIV_CYCLES.
REQ-015 busy SHALL rise at the accepting edge and stay high for exactly N cycles, N being the loaded count.
REQ-016 The counter SHALL decrement on each edge while nonzero; busy SHALL deassert at the edge where it reaches 0.
REQ-017 HI/LO SHALL update at that same edge, so new values are visible the first cycle busy=0.
REQ-018 HI/LO SHALL hold their old values throughout busy.
REQ-019 Later changes to A/B during busy SHALL NOT affect the result; the latched operands are used.
REQ-020 MULT: {HI,LO} SHALL equal the 64-bit signed product of the latched operands.
REQ-021 MULTU: {HI,LO} SHALL equal the 64-bit unsigned product of the latched operands.
REQ-022 DIV: LO SHALL be the signed quotient, truncated toward zero, and HI the remainder, taking the sign of the dividend.
REQ-023 DIVU: LO SHALL be the unsigned quotient and HI the unsigned remainder.
REQ-024 Divide by zero (B=0) SHALL still assert busy for DIV_CYCLES cycles but SHALL leave HI and LO unchanged.
REQ-025 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-026 An accepted MTHI/MTLO SHALL write A into HI/LO at the accepting edge, with no busy assertion (single-cycle).
REQ-027 An accepted NONE or reserved op SHALL do nothing.
REQ-028 A new request SHALL be acceptable in the first cycle busy=0 (back-to-back, no bubble).
REQ-029 The FSM SHALL have two states, IDLE and BUSY, with busy a registered output equal to (state==BUSY).

Reset
REQ-030 reset=1 at a rising edge SHALL clear HI=0, LO=0, busy=0, the counter and the latched operands, and force IDLE.
REQ-031 Reset SHALL take priority over start and over any in-flight operation; an aborted operation SHALL never write HI/LO.
REQ-032 An operation SHALL be acceptable in the first cycle after reset deasserts.

Verification
REQ-033 Reset, then MULT A=0xFFFFFFFE (-2), B=3 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-034 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 busy cycles, HI=0xFFFFFFFE, LO=0x00000001.
REQ-035 DIV A=0xFFFFFFF9 (-7), B=2, with A/B changed mid-busy -> 10 busy cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-036 DIVU A=7, B=0 with HI=0x11, LO=0x22 preloaded via MTHI/MTLO -> busy 10 cycles; HI=0x11, LO=0x22 unchanged.
REQ-037 MTLO issued during busy -> ignored; MTHI issued the cycle busy falls -> HI=A next cycle, busy stays 0.
REQ-038 reset asserted at the 3rd busy cycle of DIV -> next cycle busy=0, HI=LO=0; no late write after reset release.
